// File: rtl/mux8way_arbiter.sv
// mux8way_arbiter: round-robin 8:1 valid/ready merge with optional per-source burst hold
module mux8way_arbiter #(
    parameter int WIDTH = 8,
    parameter int BURST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready
);
    logic [2:0] ptr, win, prev, nptr;
    logic [3:0] beat_cnt, ncnt;
    logic       prev_v, xfer, same, hold, sw;
    always_comb begin
        win = ptr;
        for (int k = 7; k >= 0; k--)
            if (in_valid[ptr + 3'(k)]) win = ptr + 3'(k);
    end
    // rst_n gates the grant so nothing is accepted while reset is held
    assign xfer     = rst_n && (!out_valid || out_ready) && |in_valid;
    assign in_ready = xfer ? 8'b1 << win : 8'b0;
    assign same     = prev_v && win == prev;
    assign hold     = BURST > 1 && same && beat_cnt < 4'(BURST - 1);
    assign sw       = BURST > 1 && !same;
    assign nptr     = hold || sw ? win : win + 3'd1;
    assign ncnt     = hold ? beat_cnt + 4'd1 : sw ? 4'd1 : 4'd0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
            beat_cnt  <= '0;
            prev      <= '0;
            prev_v    <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[win*WIDTH +: WIDTH];
            out_sel   <= win;
            ptr       <= nptr;
            beat_cnt  <= ncnt;
            prev      <= win;
            prev_v    <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
